// File: rtl/uart_tx_frame_if.sv
// Parallel-word offer and serial-line status between the TX controller and the UART framer.
interface uart_tx_frame_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] p_data;
  logic                  data_valid;
  logic                  par_en;
  logic                  par_typ;
  logic                  tx_out;
  logic                  busy;

  modport master (
    output p_data, data_valid, par_en, par_typ,
    input  tx_out, busy
  );

  modport slave (
    input  p_data, data_valid, par_en, par_typ,
    output tx_out, busy
  );
endinterface

// File: rtl/uart_tx_frame.sv
// UART transmit framer: start bit, DATA_WIDTH data bits LSB first, optional parity, one stop bit.
// One clk period is one bit time; tx_out and busy come straight from flops.
module uart_tx_frame #(
  parameter int DATA_WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  uart_tx_frame_if.slave  io_tx
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam int CW = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [CW-1:0]         r_cnt;
  logic                  r_par_en;
  logic                  r_par_bit;
  logic                  r_tx;
  logic                  r_busy;

  state_t                w_state;
  logic [DATA_WIDTH-1:0] w_shift;
  logic [CW-1:0]         w_cnt;
  logic                  w_par_en;
  logic                  w_par_bit;
  logic                  w_tx;
  logic                  w_busy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_cnt     <= '0;
      r_par_en  <= 1'b0;
      r_par_bit <= 1'b0;
      r_tx      <= 1'b1;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_shift   <= w_shift;
      r_cnt     <= w_cnt;
      r_par_en  <= w_par_en;
      r_par_bit <= w_par_bit;
      r_tx      <= w_tx;
      r_busy    <= w_busy;
    end
  end

  // Next-state logic computes the bit each state's successor must show, so tx_out is already valid on entry.
  always_comb begin
    w_state   = r_state;
    w_shift   = r_shift;
    w_cnt     = r_cnt;
    w_par_en  = r_par_en;
    w_par_bit = r_par_bit;
    w_tx      = r_tx;
    w_busy    = r_busy;
    case (r_state)
      IDLE: begin
        w_tx   = 1'b1;
        w_busy = 1'b0;
        if (io_tx.data_valid) begin
          w_shift   = io_tx.p_data;
          w_par_en  = io_tx.par_en;
          w_par_bit = io_tx.par_typ ? ~^io_tx.p_data : ^io_tx.p_data;
          w_cnt     = '0;
          w_state   = START;
          w_tx      = 1'b0;
          w_busy    = 1'b1;
        end
      end
      START: begin
        w_tx    = r_shift[0];
        w_shift = r_shift >> 1;
        w_cnt   = '0;
        w_state = DATA;
      end
      DATA: begin
        if (r_cnt == LAST_BIT) begin
          if (r_par_en) begin
            w_state = PARITY;
            w_tx    = r_par_bit;
          end else begin
            w_state = STOP;
            w_tx    = 1'b1;
          end
        end else begin
          w_cnt   = r_cnt + CW'(1);
          w_tx    = r_shift[0];
          w_shift = r_shift >> 1;
        end
      end
      PARITY: begin
        w_state = STOP;
        w_tx    = 1'b1;
      end
      STOP: begin
        w_state = IDLE;
        w_tx    = 1'b1;
        w_busy  = 1'b0;
      end
      default: begin
        w_state = IDLE;
        w_tx    = 1'b1;
        w_busy  = 1'b0;
      end
    endcase
  end

  assign io_tx.tx_out = r_tx;
  assign io_tx.busy   = r_busy;

endmodule
